// File: rtl/vram_arbiter.sv
// Shares one single-port 32 KB screen RAM between video fetch (absolute priority), CPU and loader.
// Latency: grant at sampling edge E, RAM access at E+1, data/ack/valid registered at E+2.
// Backpressure: video is never stalled; CPU/loader hold req until a one-cycle ack, one access in flight each.
module vram_arbiter #(
    parameter logic [3:0] STARVE_LIMIT = 4'd8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic [7:0]  vid_dout,
    output logic        vid_valid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [14:0] ldr_addr,
    input  logic [7:0]  ldr_din,
    output logic [7:0]  ldr_dout,
    output logic        ldr_ack,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_LDR  = 2'd3
    } owner_t;

    owner_t      grant;
    owner_t      s1_owner;
    owner_t      s2_owner;
    logic        s2_we;
    logic        cpu_pend;
    logic        ldr_pend;
    logic [3:0]  ldr_wait;
    logic        cpu_elig;
    logic        ldr_elig;
    logic        ldr_first;

    // A requester is blocked while its access is in flight and during its ack cycle.
    assign cpu_elig  = cpu_req & ~cpu_pend & ~cpu_ack;
    assign ldr_elig  = ldr_req & ~ldr_pend & ~ldr_ack;
    assign ldr_first = (ldr_wait == STARVE_LIMIT);

    // Pick this slot's owner: video first, then CPU unless the loader has starved long enough.
    always_comb begin
        grant = OWN_IDLE;
        if (vid_req) begin
            grant = OWN_VID;
        end else if (cpu_elig && ldr_elig) begin
            grant = ldr_first ? OWN_LDR : OWN_CPU;
        end else if (cpu_elig) begin
            grant = OWN_CPU;
        end else if (ldr_elig) begin
            grant = OWN_LDR;
        end
    end

    // Stage 1: drive the RAM port for the granted owner; address/data hold when idle.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            s1_owner <= OWN_IDLE;
        end else begin
            s1_owner <= grant;
            ram_we   <= 1'b0;
            case (grant)
                OWN_VID: begin
                    ram_addr <= vid_addr;
                end
                OWN_CPU: begin
                    ram_addr <= cpu_addr;
                    ram_din  <= cpu_din;
                    ram_we   <= cpu_we;
                end
                OWN_LDR: begin
                    ram_addr <= ldr_addr;
                    ram_din  <= ldr_din;
                    ram_we   <= ldr_we;
                end
                default: ;
            endcase
        end
    end

    // Stage 2: carry the owner and direction while the RAM produces read data.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            s2_owner <= OWN_IDLE;
            s2_we    <= 1'b0;
        end else begin
            s2_owner <= s1_owner;
            s2_we    <= ram_we;
        end
    end

    // Return stage: pulse the owner's ack/valid and capture read data (writes leave dout alone).
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            vid_dout  <= '0;
            cpu_dout  <= '0;
            ldr_dout  <= '0;
        end else begin
            vid_valid <= (s2_owner == OWN_VID);
            cpu_ack   <= (s2_owner == OWN_CPU);
            ldr_ack   <= (s2_owner == OWN_LDR);
            if (s2_owner == OWN_VID) begin
                vid_dout <= ram_dout;
            end
            if (s2_owner == OWN_CPU && !s2_we) begin
                cpu_dout <= ram_dout;
            end
            if (s2_owner == OWN_LDR && !s2_we) begin
                ldr_dout <= ram_dout;
            end
        end
    end

    // In-flight flags: set on grant, cleared on the edge that raises the ack.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cpu_pend <= 1'b0;
            ldr_pend <= 1'b0;
        end else begin
            if (grant == OWN_CPU) begin
                cpu_pend <= 1'b1;
            end else if (s2_owner == OWN_CPU) begin
                cpu_pend <= 1'b0;
            end
            if (grant == OWN_LDR) begin
                ldr_pend <= 1'b1;
            end else if (s2_owner == OWN_LDR) begin
                ldr_pend <= 1'b0;
            end
        end
    end

    // Count CPU wins over a waiting loader; any loader grant restarts the count.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ldr_wait <= '0;
        end else if (grant == OWN_LDR) begin
            ldr_wait <= '0;
        end else if (grant == OWN_CPU && ldr_elig && ldr_wait != STARVE_LIMIT) begin
            ldr_wait <= ldr_wait + 4'd1;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM on the physical port.
// Latency: checks sample 1 time unit after each rising edge, inputs change at the same point.
// Backpressure: the bench holds CPU/loader requests until the ack it expects, then drops them.
module tb_vram_arbiter;

    logic        clk_sys;
    logic        reset;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic [7:0]  vid_dout;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        ldr_req;
    logic        ldr_we;
    logic [14:0] ldr_addr;
    logic [7:0]  ldr_din;
    logic [7:0]  ldr_dout;
    logic        ldr_ack;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;

    logic [7:0]  mem [0:32767];
    logic        pl_we;
    logic [14:0] pl_addr;
    logic [7:0]  pl_dat;

    int total;
    int bad;
    int n_ack;

    vram_arbiter #(.STARVE_LIMIT(4'd8)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_dout  (vid_dout),
        .vid_valid (vid_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_din   (ldr_din),
        .ldr_dout  (ldr_dout),
        .ldr_ack   (ldr_ack),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Single-port synchronous RAM: read data appears the cycle after the address.
    always @(posedge clk_sys) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_dat;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vid_valid"}, {31'd0, vid_valid}, 32'd0);
        chk({tag, "_cpu_ack"},   {31'd0, cpu_ack},   32'd0);
        chk({tag, "_ldr_ack"},   {31'd0, ldr_ack},   32'd0);
        chk({tag, "_vid_dout"},  {24'd0, vid_dout},  32'd0);
        chk({tag, "_cpu_dout"},  {24'd0, cpu_dout},  32'd0);
        chk({tag, "_ldr_dout"},  {24'd0, ldr_dout},  32'd0);
        chk({tag, "_ram_we"},    {31'd0, ram_we},    32'd0);
        chk({tag, "_ram_addr"},  {17'd0, ram_addr},  32'd0);
        chk({tag, "_ram_din"},   {24'd0, ram_din},   32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_din = '0;
        pl_we = 1'b0; pl_addr = '0; pl_dat = '0;

        // Reset: preload 0x1800..0x1805 with A0..A5 while the arbiter is held.
        for (int i = 0; i < 6; i++) begin
            pl_we = 1'b1;
            pl_addr = 15'h1800 + 15'(i);
            pl_dat = 8'hA0 + 8'(i);
            tick();
        end
        pl_we = 1'b0;
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Video stream: six back-to-back strobes return A0..A5 two edges later.
        for (int c = 0; c < 10; c++) begin
            vid_req = (c < 6);
            vid_addr = 15'h1800 + 15'(c);
            tick();
            chk("vs_valid", {31'd0, vid_valid}, (c >= 2 && c < 8) ? 32'd1 : 32'd0);
            if (c >= 2 && c < 8) chk("vs_dout", {24'd0, vid_dout}, 32'hA0 + 32'(c - 2));
            chk("vs_cpu_ack", {31'd0, cpu_ack}, 32'd0);
            chk("vs_ram_we", {31'd0, ram_we}, 32'd0);
        end
        vid_req = 1'b0;
        tick();

        // CPU write 0x5A to 0x2000.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h2000; cpu_din = 8'h5A;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("wr_ram_we", {31'd0, ram_we}, (c == 0) ? 32'd1 : 32'd0);
            if (c == 0) chk("wr_ram_addr", {17'd0, ram_addr}, 32'h2000);
            chk("wr_ack", {31'd0, cpu_ack}, (c == 2) ? 32'd1 : 32'd0);
            chk("wr_dout_kept", {24'd0, cpu_dout}, 32'd0);
            if (c == 2) begin
                chk("wr_mem", {24'd0, mem[15'h2000]}, 32'h5A);
                cpu_req = 1'b0;
            end
        end

        // CPU read of the same address.
        cpu_req = 1'b1; cpu_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rd_ram_we", {31'd0, ram_we}, 32'd0);
            chk("rd_ack", {31'd0, cpu_ack}, (c == 2) ? 32'd1 : 32'd0);
            if (c == 2) begin
                chk("rd_dout", {24'd0, cpu_dout}, 32'h5A);
                cpu_req = 1'b0;
            end
        end
        tick();

        // Collision: video, then CPU, then loader on consecutive slots.
        vid_req = 1'b1; vid_addr = 15'h1801;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h2000;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 15'h1802;
        for (int c = 0; c < 6; c++) begin
            tick();
            vid_req = 1'b0;
            if (c == 0) chk("col_addr0", {17'd0, ram_addr}, 32'h1801);
            if (c == 1) chk("col_addr1", {17'd0, ram_addr}, 32'h2000);
            if (c == 2) chk("col_addr2", {17'd0, ram_addr}, 32'h1802);
            chk("col_vid", {31'd0, vid_valid}, (c == 2) ? 32'd1 : 32'd0);
            chk("col_cpu", {31'd0, cpu_ack}, (c == 3) ? 32'd1 : 32'd0);
            chk("col_ldr", {31'd0, ldr_ack}, (c == 4) ? 32'd1 : 32'd0);
            if (c == 2) chk("col_vid_dout", {24'd0, vid_dout}, 32'hA1);
            if (c == 3) begin
                chk("col_cpu_dout", {24'd0, cpu_dout}, 32'h5A);
                cpu_req = 1'b0;
            end
            if (c == 4) begin
                chk("col_ldr_dout", {24'd0, ldr_dout}, 32'hA2);
                ldr_req = 1'b0;
            end
        end
        tick();

        // Held CPU request: an ack every 4 cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1803;
        n_ack = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cpu_ack) n_ack++;
            chk("b2b_ack", {31'd0, cpu_ack}, (c % 4 == 2) ? 32'd1 : 32'd0);
            if (c % 4 == 2) chk("b2b_dout", {24'd0, cpu_dout}, 32'hA3);
        end
        cpu_req = 1'b0;
        chk("b2b_count", 32'(n_ack), 32'd5);
        tick();
        tick();

        // Starvation: video fills three of every four slots so CPU keeps beating the loader.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1805;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 15'h1804;
        vid_addr = 15'h1800;
        for (int c = 0; c < 72; c++) begin
            int g;
            vid_req = (c % 4 != 0);
            tick();
            g = c - 2;
            chk("stv_cpu", {31'd0, cpu_ack},
                (g >= 0 && g % 4 == 0 && g % 36 != 32) ? 32'd1 : 32'd0);
            chk("stv_ldr", {31'd0, ldr_ack},
                (g >= 0 && g % 4 == 0 && g % 36 == 32) ? 32'd1 : 32'd0);
            if (c == 28) chk("stv_wait_sat", {28'd0, dut.ldr_wait}, 32'd8);
            if (c == 32) chk("stv_wait_clr", {28'd0, dut.ldr_wait}, 32'd0);
        end
        vid_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Reset one edge after a CPU read grant: no ack, outputs clear at once.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1801;
        tick();
        tick();
        chk("rst_pre_addr", {17'd0, ram_addr}, 32'h1801);
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_no_ack", {31'd0, cpu_ack}, 32'd0);
        end
        reset = 1'b0;
        tick();
        chk("rst_idle_ack", {31'd0, cpu_ack}, 32'd0);

        // Normal read after reset.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1800;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_ack", {31'd0, cpu_ack}, (c == 2) ? 32'd1 : 32'd0);
        end
        chk("post_dout", {24'd0, cpu_dout}, 32'hA0);
        cpu_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
